// File: rtl/threshold_loader.sv
// threshold_loader: assembles the two-lane threshold write stream into
// per-beam shadow registers and atomically commits trigger/subthreshold
// values to the beam comparators on a validated update strobe.
module threshold_loader #(
  parameter int                NBEAMS       = 46,
  parameter int                TWIDTH       = 18,
  parameter logic [TWIDTH-1:0] DEFAULT_TRIG = 18'h3FFFF,
  parameter logic [TWIDTH-1:0] DEFAULT_SUB  = 18'h3FFFF
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [2*TWIDTH-1:0]      thresh_i,
  input  logic [1:0]               thresh_wr_i,
  input  logic [1:0]               thresh_update_i,
  input  logic                     err_clr_i,
  output logic [NBEAMS*TWIDTH-1:0] trig_thresh_o,
  output logic [NBEAMS*TWIDTH-1:0] subthresh_o,
  output logic                     applied_o,
  output logic                     load_err_o,
  output logic                     underflow_o,
  output logic [7:0]               commit_count_o
);

  localparam int NDUAL  = (NBEAMS + 1) / 2;
  localparam int NWORDS = 2 * NDUAL;
  localparam int WCW    = $clog2(NWORDS) + 1;

  // Shadow storage indexed by beam number 2d+k; the last lane1 slot is
  // unused when NBEAMS is odd.
  logic [TWIDTH-1:0] sh_trig  [NWORDS];
  logic [TWIDTH-1:0] sh_delta [NWORDS];
  logic [TWIDTH-1:0] trig_q   [NBEAMS];
  logic [TWIDTH-1:0] sub_q    [NBEAMS];
  logic [TWIDTH-1:0] new_sub  [NBEAMS];

  logic [WCW-1:0] wcnt;
  logic [WCW-1:0] d_sel;
  logic           ld_err;
  logic           uf_any;

  logic wr_any, wr_pair, upd_any, upd_pair, full;
  logic wr_accept, wr_err, upd_valid, upd_err;

  // Decode strobes into accept / error / commit conditions.
  always_comb begin
    wr_any    = |thresh_wr_i;
    wr_pair   = &thresh_wr_i;
    upd_any   = |thresh_update_i;
    upd_pair  = &thresh_update_i;
    full      = (wcnt == WCW'(NWORDS));
    d_sel     = WCW'(NDUAL - 1) - (wcnt >> 1);
    wr_accept = wr_pair && !upd_any && !full;
    wr_err    = !upd_any && ((wr_any && !wr_pair) || (wr_pair && full));
    upd_valid = upd_pair && full && !wr_any && !ld_err;
    upd_err   = upd_any && !upd_valid;
  end

  // Subthreshold = trigger - delta, clamped to zero on underflow.
  always_comb begin
    uf_any = 1'b0;
    for (int b = 0; b < NBEAMS; b++) begin
      if (sh_delta[b] > sh_trig[b]) begin
        new_sub[b] = '0;
        uf_any     = 1'b1;
      end else begin
        new_sub[b] = sh_trig[b] - sh_delta[b];
      end
    end
  end

  // Shadow load, write counter, commit and sticky flags.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < NWORDS; i++) begin
        sh_trig[i]  <= '0;
        sh_delta[i] <= '0;
      end
      for (int b = 0; b < NBEAMS; b++) begin
        trig_q[b] <= DEFAULT_TRIG;
        sub_q[b]  <= DEFAULT_SUB;
      end
      wcnt           <= '0;
      ld_err         <= 1'b0;
      applied_o      <= 1'b0;
      load_err_o     <= 1'b0;
      underflow_o    <= 1'b0;
      commit_count_o <= '0;
    end else begin
      applied_o <= 1'b0;
      if (wr_accept) begin
        for (int i = 0; i < NDUAL; i++) begin
          if (d_sel == WCW'(i)) begin
            if (wcnt[0]) begin
              sh_trig[2*i]   <= thresh_i[TWIDTH-1:0];
              sh_trig[2*i+1] <= thresh_i[2*TWIDTH-1:TWIDTH];
            end else begin
              sh_delta[2*i]   <= thresh_i[TWIDTH-1:0];
              sh_delta[2*i+1] <= thresh_i[2*TWIDTH-1:TWIDTH];
            end
          end
        end
        wcnt <= wcnt + WCW'(1);
      end
      if (wr_err) ld_err <= 1'b1;
      // Any update strobe ends the load, valid or not.
      if (upd_any) begin
        wcnt   <= '0;
        ld_err <= 1'b0;
      end
      if (upd_valid) begin
        for (int b = 0; b < NBEAMS; b++) begin
          trig_q[b] <= sh_trig[b];
          sub_q[b]  <= new_sub[b];
        end
        applied_o      <= 1'b1;
        commit_count_o <= commit_count_o + 8'd1;
      end
      load_err_o  <= wr_err | upd_err | (load_err_o & ~err_clr_i);
      underflow_o <= (upd_valid & uf_any) | (underflow_o & ~err_clr_i);
    end
  end

  // Flatten active thresholds onto the output buses.
  for (genvar b = 0; b < NBEAMS; b++) begin : g_out
    assign trig_thresh_o[b*TWIDTH +: TWIDTH] = trig_q[b];
    assign subthresh_o[b*TWIDTH +: TWIDTH]   = sub_q[b];
  end

endmodule

// File: tb/tb_threshold_loader.sv
// Directed bench for threshold_loader: a 46-beam instance for the main
// load/commit/error scenarios and a 5-beam instance for the odd-beam case.
module tb_threshold_loader;

  logic        aclk = 1'b0;
  logic        aresetn;
  always #5 aclk = ~aclk;

  logic [35:0]  thr_a,  thr_b;
  logic [1:0]   wr_a,   wr_b;
  logic [1:0]   upd_a,  upd_b;
  logic         clr_a,  clr_b;
  logic [827:0] trig_a, sub_a;
  logic [89:0]  trig_b, sub_b;
  logic         app_a, lerr_a, uf_a;
  logic         app_b, lerr_b, uf_b;
  logic [7:0]   cnt_a, cnt_b;

  int n_vec  = 0;
  int n_miss = 0;

  threshold_loader u_dut_a (
    .aclk(aclk), .aresetn(aresetn), .thresh_i(thr_a), .thresh_wr_i(wr_a),
    .thresh_update_i(upd_a), .err_clr_i(clr_a), .trig_thresh_o(trig_a),
    .subthresh_o(sub_a), .applied_o(app_a), .load_err_o(lerr_a),
    .underflow_o(uf_a), .commit_count_o(cnt_a)
  );

  threshold_loader #(.NBEAMS(5)) u_dut_b (
    .aclk(aclk), .aresetn(aresetn), .thresh_i(thr_b), .thresh_wr_i(wr_b),
    .thresh_update_i(upd_b), .err_clr_i(clr_b), .trig_thresh_o(trig_b),
    .subthresh_o(sub_b), .applied_o(app_b), .load_err_o(lerr_b),
    .underflow_o(uf_b), .commit_count_o(cnt_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // One clock on instance A; inputs return to idle #1 after the edge.
  task automatic a_cyc(input logic [1:0] wr, input logic [1:0] up,
                       input logic [35:0] data, input logic clr);
    wr_a = wr; upd_a = up; thr_a = data; clr_a = clr;
    @(posedge aclk); #1;
    wr_a = 2'b00; upd_a = 2'b00; thr_a = '0; clr_a = 1'b0;
  endtask

  task automatic b_cyc(input logic [1:0] wr, input logic [1:0] up, input logic [35:0] data);
    wr_b = wr; upd_b = up; thr_b = data;
    @(posedge aclk); #1;
    wr_b = 2'b00; upd_b = 2'b00; thr_b = '0;
  endtask

  // nw paired writes: delta 100 (bad_delta for bad_dual), trigger base+d;
  // a single-lane write is inserted before write index glitch_at.
  task automatic a_load(input int nw, input int base, input int bad_dual,
                        input int bad_delta, input int glitch_at);
    int d, v;
    for (int k = 0; k < nw; k++) begin
      if (k == glitch_at) a_cyc(2'b01, 2'b00, '0, 1'b0);
      d = (k < 46) ? 22 - (k >> 1) : 0;
      if (k % 2 == 1) v = base + d;
      else            v = (d == bad_dual) ? bad_delta : 100;
      a_cyc(2'b11, 2'b00, {18'(v), 18'(v)}, 1'b0);
    end
  endtask

  task automatic chk_a_beams(input string tag, input int base, input int bad_dual);
    int et, es;
    for (int b = 0; b < 46; b++) begin
      et = base + b / 2;
      es = (b / 2 == bad_dual) ? 0 : et - 100;
      chk($sformatf("%s trig[%0d]", tag, b), 64'(trig_a[b*18 +: 18]), 64'(et));
      chk($sformatf("%s sub[%0d]", tag, b), 64'(sub_a[b*18 +: 18]), 64'(es));
    end
  endtask

  initial begin
    aresetn = 1'b0;
    wr_a = '0; upd_a = '0; thr_a = '0; clr_a = 1'b0;
    wr_b = '0; upd_b = '0; thr_b = '0; clr_b = 1'b0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;

    // reset state
    chk("rst trig0", 64'(trig_a[17:0]), 64'h3FFFF);
    chk("rst sub45", 64'(sub_a[45*18 +: 18]), 64'h3FFFF);
    chk("rst applied", 64'(app_a), 0);
    chk("rst lerr", 64'(lerr_a), 0);
    chk("rst uf", 64'(uf_a), 0);
    chk("rst cnt", 64'(cnt_a), 0);

    // clean full load
    a_load(46, 1000, -1, 0, -1);
    a_cyc(2'b00, 2'b11, '0, 1'b0);
    chk("full applied", 64'(app_a), 1);
    chk("full cnt", 64'(cnt_a), 1);
    chk("full lerr", 64'(lerr_a), 0);
    chk("full uf", 64'(uf_a), 0);
    chk("full trig0", 64'(trig_a[17:0]), 1000);
    chk("full sub0", 64'(sub_a[17:0]), 900);
    chk("full trig45", 64'(trig_a[45*18 +: 18]), 1022);
    chk("full sub45", 64'(sub_a[45*18 +: 18]), 922);
    chk_a_beams("full", 1000, -1);
    a_cyc(2'b00, 2'b00, '0, 1'b0);
    chk("applied pulse", 64'(app_a), 0);

    // underflow on dual-beam 5
    a_load(46, 1000, 5, 2000, -1);
    a_cyc(2'b00, 2'b11, '0, 1'b0);
    chk("uf applied", 64'(app_a), 1);
    chk("uf flag", 64'(uf_a), 1);
    chk("uf cnt", 64'(cnt_a), 2);
    chk_a_beams("uf", 1000, 5);
    a_cyc(2'b00, 2'b00, '0, 1'b1);
    chk("uf clr", 64'(uf_a), 0);

    // short load: no commit
    a_load(44, 2000, -1, 0, -1);
    a_cyc(2'b00, 2'b11, '0, 1'b0);
    chk("short applied", 64'(app_a), 0);
    chk("short lerr", 64'(lerr_a), 1);
    chk("short cnt", 64'(cnt_a), 2);
    chk_a_beams("short", 1000, 5);
    a_load(46, 1000, -1, 0, -1);
    a_cyc(2'b00, 2'b11, '0, 1'b0);
    chk("after short applied", 64'(app_a), 1);
    chk("after short lerr", 64'(lerr_a), 1);
    chk("after short cnt", 64'(cnt_a), 3);
    chk_a_beams("after short", 1000, -1);
    a_cyc(2'b00, 2'b00, '0, 1'b1);
    chk("lerr clr", 64'(lerr_a), 0);

    // single-lane write mid-load
    a_load(46, 2000, -1, 0, 10);
    chk("glitch lerr", 64'(lerr_a), 1);
    a_cyc(2'b00, 2'b11, '0, 1'b0);
    chk("glitch applied", 64'(app_a), 0);
    chk("glitch cnt", 64'(cnt_a), 3);
    chk_a_beams("glitch", 1000, -1);
    a_cyc(2'b00, 2'b00, '0, 1'b1);

    // overrun
    a_load(47, 2000, -1, 0, -1);
    chk("overrun lerr", 64'(lerr_a), 1);
    a_cyc(2'b00, 2'b11, '0, 1'b0);
    chk("overrun applied", 64'(app_a), 0);
    chk("overrun cnt", 64'(cnt_a), 3);
    a_cyc(2'b00, 2'b00, '0, 1'b1);
    chk("overrun clr", 64'(lerr_a), 0);

    // write and update together
    a_load(46, 2000, -1, 0, -1);
    a_cyc(2'b11, 2'b11, {18'd5, 18'd5}, 1'b0);
    chk("wr+upd applied", 64'(app_a), 0);
    chk("wr+upd lerr", 64'(lerr_a), 1);
    chk("wr+upd cnt", 64'(cnt_a), 3);
    a_cyc(2'b00, 2'b00, '0, 1'b1);

    // single-lane update after full load
    a_load(46, 2000, -1, 0, -1);
    a_cyc(2'b00, 2'b01, '0, 1'b0);
    chk("upd01 applied", 64'(app_a), 0);
    chk("upd01 lerr", 64'(lerr_a), 1);
    a_cyc(2'b00, 2'b00, '0, 1'b1);
    a_load(46, 2000, -1, 0, -1);
    a_cyc(2'b00, 2'b11, '0, 1'b0);
    chk("base2000 applied", 64'(app_a), 1);
    chk("base2000 cnt", 64'(cnt_a), 4);
    chk("base2000 lerr", 64'(lerr_a), 0);
    chk_a_beams("base2000", 2000, -1);

    // reset mid-load
    a_load(20, 1000, -1, 0, -1);
    aresetn = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    chk("midrst trig0", 64'(trig_a[17:0]), 64'h3FFFF);
    chk("midrst sub45", 64'(sub_a[45*18 +: 18]), 64'h3FFFF);
    chk("midrst cnt", 64'(cnt_a), 0);
    a_load(46, 1000, -1, 0, -1);
    chk("midrst preupd trig0", 64'(trig_a[17:0]), 64'h3FFFF);
    a_cyc(2'b00, 2'b11, '0, 1'b0);
    chk("midrst applied", 64'(app_a), 1);
    chk("midrst cnt1", 64'(cnt_a), 1);
    chk("midrst lerr", 64'(lerr_a), 0);
    chk_a_beams("midrst", 1000, -1);

    // 5-beam instance: lane0 trig 300+10d, lane1 305+10d; delta 10+d / 20+d
    chk("b rst trig4", 64'(trig_b[4*18 +: 18]), 64'h3FFFF);
    for (int k = 0; k < 6; k++) begin
      int d;
      d = 2 - (k >> 1);
      if (k % 2 == 1) b_cyc(2'b11, 2'b00, {18'(305 + 10*d), 18'(300 + 10*d)});
      else            b_cyc(2'b11, 2'b00, {18'(20 + d), 18'(10 + d)});
    end
    b_cyc(2'b00, 2'b11, '0);
    chk("b applied", 64'(app_b), 1);
    chk("b cnt", 64'(cnt_b), 1);
    chk("b lerr", 64'(lerr_b), 0);
    chk("b uf", 64'(uf_b), 0);
    for (int b = 0; b < 5; b++) begin
      int d, k, et, es;
      d = b / 2; k = b % 2;
      et = 300 + 10*d + 5*k;
      es = et - (10 + d + 10*k);
      chk($sformatf("b trig[%0d]", b), 64'(trig_b[b*18 +: 18]), 64'(et));
      chk($sformatf("b sub[%0d]", b), 64'(sub_b[b*18 +: 18]), 64'(es));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/threshold_loader.md
Name: threshold_loader

Overview:
- Sits directly downstream of the WISHBONE threshold block, in the aclk domain.
- Consumes the serialized two-lane threshold write stream and assembles it into per-beam shadow registers.
- On the update strobe, validates the load and atomically commits absolute trigger and subthreshold values to the beam-trigger comparators.
- Reports load errors and subthreshold underflow.

Parameters:
- NBEAMS, 46, number of beams; lane k of dual-beam d is beam 2d+k.
- TWIDTH, 18, threshold width in bits.
- DEFAULT_TRIG, 18'h3FFFF, trigger threshold after reset for every beam.
- DEFAULT_SUB, 18'h3FFFF, subthreshold after reset for every beam.

Ports:
- aclk  in  1  block clock; all logic is on the rising edge.
- aresetn  in  1  synchronous reset, active-low.
- thresh_i  in  2*TWIDTH  lane0 in [17:0], lane1 in [35:18].
- thresh_wr_i  in  2  per-lane write strobe.
- thresh_update_i  in  2  per-lane update (commit) strobe.
- err_clr_i  in  1  clears the sticky flags.
- trig_thresh_o  out  NBEAMS*TWIDTH  active trigger thresholds; beam b is in [b*18 +: 18].
- subthresh_o  out  NBEAMS*TWIDTH  active absolute subthresholds.
- applied_o  out  1  one-cycle pulse on a successful commit.
- load_err_o  out  1  sticky: malformed load.
- underflow_o  out  1  sticky: a subthreshold was clamped.
- commit_count_o  out  8  successful commits, wraps 255->0.

Behaviour:
- Derived constants:
  - NDUAL = ceil(NBEAMS/2).
  - NWORDS = 2*NDUAL.
  - Write counter wcnt is $clog2(NWORDS)+1 bits wide.
- Reset (aresetn=0 at an edge):
  - trig_thresh_o = DEFAULT_TRIG and subthresh_o = DEFAULT_SUB for all beams.
  - Shadow registers are cleared to 0.
  - wcnt=0, applied_o=0, load_err_o=0, underflow_o=0, commit_count_o=0.
  - Reset mid-load discards the partial load.
- Stream format:
  - Words arrive in descending dual-beam order, NDUAL-1 down to 0.
  - Each dual-beam sends a delta word first (even wcnt), then a trigger word (odd wcnt).
  - For a word at wcnt=k, the target dual-beam is d = NDUAL-1-(k>>1).
  - Delta = trigger - subthreshold.
- Write acceptance (thresh_wr_i == 2'b11, no update in the same cycle, wcnt < NWORDS):
  - Store lane0 and lane1 into shadow delta[d] or shadow trig[d].
  - Increment wcnt.
  - When NBEAMS is odd, lane1 of dual-beam NDUAL-1 is stored but never drives an output.
- Error conditions (each sets load_err_o; none changes outputs):
  - thresh_wr_i of 2'b01 or 2'b10: nothing stored, wcnt unchanged.
  - A write when wcnt == NWORDS (overrun): ignored.
  - thresh_update_i of 2'b01 or 2'b10: treated as an update that fails validation.
- Update (any bit of thresh_update_i set):
  - Valid only when thresh_update_i==2'b11, wcnt==NWORDS, no write in the same cycle, and no error during this load.
  - Valid: on the same edge, commit all beams.
    - trig_out[b] = shadow trig.
    - sub_out[b] = trig - delta.
    - If delta > trig, sub_out[b] = 0 and underflow_o is set.
    - applied_o pulses for 1 cycle; outputs change 1 cycle after the strobe is sampled.
    - commit_count_o increments.
  - Invalid: no commit, load_err_o set.
  - In both cases: wcnt <- 0 and the per-load error tracker is cleared.
- Simultaneous write and update: the write is discarded, the update is invalid, load_err_o is set, wcnt <- 0.
- Sticky flags:
  - err_clr_i clears load_err_o and underflow_o.
  - A same-cycle set takes priority over the clear.
- Shadow contents persist across loads; only the words that are written change.

Test Plan:
- NBEAMS=46:
  - Stimulus: 46 paired writes, trigger word = 1000+d on both lanes and delta = 100; update on the next cycle.
  - Response: applied_o pulses; beam 0 trig=1000, sub=900; beam 45 trig=1022, sub=922; commit_count_o=1; flags=0.
- Same load except delta=2000 for dual-beam 5:
  - Beams 10 and 11 have sub=0 and underflow_o=1.
  - Commit still happens; all other beams are correct.
- Short load (44 writes), then update:
  - No applied_o pulse, outputs unchanged, load_err_o=1.
  - A following full 46-word load commits correctly with load_err_o still 1.
  - err_clr_i then clears load_err_o.
- Error strobes during an otherwise full load:
  - Single-lane write thresh_wr_i=2'b01 mid-load -> load_err_o=1 and the update does not commit.
  - A 47th write -> load_err_o=1 and no commit.
- NBEAMS=5 (NDUAL=3):
  - Stimulus: 6 writes, then update.
  - Response: beam 4 comes from lane0 of dual-beam 2; the lane1 value never appears; the outputs are 5*18 bits wide.
- Reset mid-load:
  - Stimulus: aresetn low after 20 writes, then a full load.
  - Response: outputs = defaults until the full load commits; commit_count_o=1.
